ram_arbiter: RTL

Shares one RAM port among N_CORES per-core caches using round-robin arbitration with whole-burst grants. The grant is held for the full duration of a cache line fill or write-back. During atomic-flagged write-backs it broadcasts each written word to every other cache, which drives their `cache_atomic_i` snoop update. Sits between the core caches and the RAM controller in the multicore top level.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arbiter_rr_picker.sv | 32 +++
 rtl/ram_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared bus widths, arbiter state encodings and index-width helper.
package ram_arbiter_pkg;

    localparam int DATA_W      = 32;
    localparam int DATA_ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first requester after last_grant wins.
module rr_picker
    import ram_arbiter_pkg::*;
#(
    parameter int N_CORES = 4,
    localparam int IW = idx_w(N_CORES)
) (
    input  logic [N_CORES-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [N_CORES-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_CORES; i++) begin
            cand = IW'((int'(last_grant) + i) % N_CORES);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin whole-burst sharing of one RAM port among N_CORES caches,
// broadcasting atomic write-back words to the other caches as snoop updates.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int N_CORES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CORES-1:0]             req_read,
    input  logic [N_CORES-1:0]             req_write,
    input  logic [N_CORES-1:0]             req_atomic,
    input  logic [N_CORES*DATA_ADDR_W-1:0] req_addr,
    input  logic [N_CORES*DATA_W-1:0]      req_data_w,
    output logic [N_CORES-1:0]             arbiter_permit,
    output logic [N_CORES-1:0]             core_wait,
    output logic [DATA_W-1:0]              core_data_r,
    output logic [N_CORES-1:0]             snoop_valid,
    output logic [DATA_ADDR_W-1:0]         snoop_addr,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [DATA_ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]              mem_data_w,
    input  logic                           mem_wait,
    input  logic [DATA_W-1:0]              mem_data_r,
    output logic [4:0]                     beat_count
);

    localparam int IW  = idx_w(N_CORES);
    localparam int AOW = $clog2(N_CORES * DATA_ADDR_W);
    localparam int DOW = $clog2(N_CORES * DATA_W);

    arb_state_t state, state_nx;

    logic [IW-1:0]      owner, last_grant, pick_idx;
    logic [N_CORES-1:0] req, pick, owner_mask;
    logic               pick_any, busy, o_rd, o_wr, o_at, snoop;
    logic [AOW-1:0]     a_off;
    logic [DOW-1:0]     d_off;

    assign req = req_read | req_write;

    rr_picker #(.N_CORES(N_CORES)) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB_IDLE;
            owner          <= '0;
            last_grant     <= IW'(N_CORES - 1);
            arbiter_permit <= '0;
            beat_count     <= '0;
        end else begin
            state <= state_nx;
            if (state == ARB_IDLE && pick_any) begin
                owner      <= pick_idx;
                last_grant <= pick_idx;
            end
            arbiter_permit <= (state == ARB_IDLE) ? pick :
                              (state_nx == ARB_BUSY) ? arbiter_permit : '0;
            beat_count     <= (state == ARB_RELEASE) ? '0 :
                              beat_count + 5'(busy && (mem_read || mem_write) && !mem_wait);
        end
    end

    // Everything RAM- and cache-facing is combinational from the registered owner,
    // so a burst sees no extra latency once granted.
    always_comb begin
        busy        = (state == ARB_BUSY);
        owner_mask  = N_CORES'(1) << owner;
        o_rd        = req_read[owner];
        o_wr        = req_write[owner];
        o_at        = req_atomic[owner];
        a_off       = AOW'(owner) * AOW'(DATA_ADDR_W);
        d_off       = DOW'(owner) * DOW'(DATA_W);
        mem_write   = busy && o_wr;
        mem_read    = busy && o_rd && !o_wr;
        mem_addr    = req_addr[a_off +: DATA_ADDR_W];
        mem_data_w  = req_data_w[d_off +: DATA_W];
        snoop       = busy && o_wr && o_at && !mem_wait;
        snoop_valid = snoop ? ~owner_mask : '0;
        snoop_addr  = mem_addr;
        core_data_r = snoop ? mem_data_w : mem_data_r;
        core_wait   = (busy && !mem_wait) ? ~owner_mask : '1;
        state_nx    = ARB_IDLE;
        case (state)
            ARB_IDLE: state_nx = pick_any ? ARB_BUSY : ARB_IDLE;
            ARB_BUSY: state_nx = (o_rd || o_wr) ? ARB_BUSY : ARB_RELEASE;
            default:  state_nx = ARB_IDLE;
        endcase
    end

endmodule
